// File: rtl/pronoc_pkg.sv
// Shared router constants and the per-OVC status record.
package pronoc_pkg;

   // Default credit counter width; must hold the largest downstream buffer depth.
   localparam int CRDTw = 3;

   // 1: an OVC is grantable while not full; 0: while not nearly full.
   localparam int OVC_ALLOC_MODE = 1;

   // Per-OVC snapshot handed to the allocators.
   typedef struct packed {
      logic [CRDTw-1:0] credit;
      logic             full;
      logic             nearly_full;
      logic             empty;
      logic             status;
      logic             avalable;
   } ovc_info_t;

endpackage

// File: rtl/ovc_credit_cntr.sv
// Credit counter for one output VC: tracks free downstream slots and the
// captured maximum, and flags underflow/overflow attempts.
module ovc_credit_cntr #(
   parameter int CRDTw = pronoc_pkg::CRDTw
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CRDTw-1:0] i_init_val,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [CRDTw-1:0] o_cnt,
   output logic             o_full,
   output logic             o_nearly_full,
   output logic             o_empty,
   output logic             o_underflow,
   output logic             o_overflow
);

   localparam logic [CRDTw-1:0] CNT_TOP = '1;

   logic [CRDTw-1:0] r_cnt;
   logic [CRDTw-1:0] r_max;
   // Set when the neighbour advertised no credit: the maximum is then learned
   // from returning credits instead of being fixed at reset.
   logic             r_track;

   logic [CRDTw-1:0] w_cnt_nxt;
   logic [CRDTw-1:0] w_max_nxt;
   logic [CRDTw-1:0] w_cnt_plus;
   logic             w_underflow;
   logic             w_overflow;

   assign w_cnt_plus = r_cnt + CRDTw'(1);

   // Next-count decode; a simultaneous credit return and flit departure cancel.
   // NOTE: every signal assigned in always_comb gets a default first so that no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_cnt_nxt   = r_cnt;
      w_max_nxt   = r_max;
      w_underflow = 1'b0;
      w_overflow  = 1'b0;
      if (i_inc && !i_dec) begin
         if (r_cnt == CNT_TOP) begin
            w_overflow = 1'b1;
         end else if (r_track) begin
            w_cnt_nxt = w_cnt_plus;
            if (w_cnt_plus > r_max) begin
               w_max_nxt = w_cnt_plus;
            end
         end else if (r_cnt == r_max) begin
            w_overflow = 1'b1;
         end else begin
            w_cnt_nxt = w_cnt_plus;
         end
      end else if (i_dec && !i_inc) begin
         if (r_cnt == '0) begin
            w_underflow = 1'b1;
         end else begin
            w_cnt_nxt = r_cnt - CRDTw'(1);
         end
      end
   end

   // Counter state; reset reloads from the neighbour's advertised credit.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= i_init_val;
         r_max   <= i_init_val;
         r_track <= (i_init_val == '0);
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_max   <= w_max_nxt;
      end
   end

   assign o_cnt         = r_cnt;
   assign o_full        = (r_cnt == '0);
   assign o_nearly_full = (r_cnt <= CRDTw'(1));
   assign o_empty       = (r_cnt == r_max);
   assign o_underflow   = w_underflow;
   assign o_overflow    = w_overflow;

endmodule

// File: rtl/ovc_credit_tracker.sv
// Output-port credit tracker: one credit counter per VC plus allocation
// status, availability and sticky error reporting.
module ovc_credit_tracker #(
   parameter int V              = 4,
   parameter int CRDTw          = pronoc_pkg::CRDTw,
   parameter int OVC_ALLOC_MODE = pronoc_pkg::OVC_ALLOC_MODE
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [V*CRDTw-1:0]            credit_init_val,
   input  logic [V-1:0]                  credit_in,
   input  logic                          flit_wr,
   input  logic [V-1:0]                  flit_vc,
   input  logic [V-1:0]                  ovc_is_allocated,
   input  logic [V-1:0]                  ovc_is_released,
   output logic [V*CRDTw-1:0]            credit,
   output logic [V-1:0]                  full,
   output logic [V-1:0]                  nearly_full,
   output logic [V-1:0]                  empty,
   output logic [V-1:0]                  status,
   output logic [V-1:0]                  avalable,
   output logic [1:0]                    err,
   output pronoc_pkg::ovc_info_t [V-1:0] ovc_info
);

   localparam int PKG_CRDTW = pronoc_pkg::CRDTw;

   logic [V-1:0]     w_dec;
   logic [V-1:0]     w_full;
   logic [V-1:0]     w_underflow;
   logic [V-1:0]     w_overflow;
   logic [CRDTw-1:0] w_cnt [V];
   logic [V-1:0]     r_status;
   logic [1:0]       r_err;

   // A multi-hot flit_vc decrements every flagged VC.
   assign w_dec = {V{flit_wr}} & flit_vc;

   for (genvar i = 0; i < V; i++) begin : g_vc
      ovc_credit_cntr #(
         .CRDTw(CRDTw)
      ) u_cntr (
         .clk          (clk),
         .reset        (reset),
         .i_init_val   (credit_init_val[i*CRDTw +: CRDTw]),
         .i_inc        (credit_in[i]),
         .i_dec        (w_dec[i]),
         .o_cnt        (w_cnt[i]),
         .o_full       (w_full[i]),
         .o_nearly_full(nearly_full[i]),
         .o_empty      (empty[i]),
         .o_underflow  (w_underflow[i]),
         .o_overflow   (w_overflow[i])
      );

      assign credit[i*CRDTw +: CRDTw] = w_cnt[i];

      assign ovc_info[i].credit      = PKG_CRDTW'(w_cnt[i]);
      assign ovc_info[i].full        = w_full[i];
      assign ovc_info[i].nearly_full = nearly_full[i];
      assign ovc_info[i].empty       = empty[i];
      assign ovc_info[i].status      = r_status[i];
      assign ovc_info[i].avalable    = avalable[i];
   end

   // Allocation status (set beats release) and sticky error flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_status <= '0;
         r_err    <= '0;
      end else begin
         r_status <= (r_status & ~ovc_is_released) | ovc_is_allocated;
         r_err    <= r_err | {(|w_overflow), (|w_underflow)};
      end
   end

   if (OVC_ALLOC_MODE == 1) begin : g_avail_full
      assign avalable = ~r_status & ~w_full;
   end else begin : g_avail_nfull
      assign avalable = ~r_status & ~nearly_full;
   end

   assign full   = w_full;
   assign status = r_status;
   assign err    = r_err;

endmodule

// File: doc/ovc_credit_tracker.md
OVC_CREDIT_TRACKER -- requirements
Module: ovc_credit_tracker

Interface
REQ-001 Parameter V, default 4: number of virtual channels per output port.
REQ-002 Parameter CRDTw, default 3: credit counter width; SHALL hold max(B,LB) without wrap.
REQ-003 Parameter OVC_ALLOC_MODE, default 1: 1 = availability gated by full; 0 = availability gated by nearly_full.
REQ-004 clk  input  1  router clock.
REQ-005 reset  input  1  synchronous reset, active-high; single clock domain only.
REQ-006 credit_init_val  input  V*CRDTw  per-VC initial credit from the neighbour's ctrl channel; sampled only while reset=1.
REQ-007 credit_in  input  V  one-bit-per-VC credit return from the downstream router.
REQ-008 flit_wr  input  1  a flit leaves this output port this cycle.
REQ-009 flit_vc  input  V  one-hot VC of the departing flit; ignored when flit_wr=0.
REQ-010 ovc_is_allocated  input  V  per-VC allocation pulse from the VC allocator.
REQ-011 ovc_is_released  input  V  per-VC release pulse on tail departure.
REQ-012 credit  output  V*CRDTw  current available credit per VC.
REQ-013 full / nearly_full / empty  output  V each  per-VC occupancy flags.
REQ-014 status  output  V  1 = OVC allocated.
REQ-015 avalable  output  V  OVC may be granted to a new packet.
REQ-016 err  output  2  sticky error flags: bit0 credit underflow, bit1 credit overflow.

Function
REQ-017 Each VC SHALL hold a credit counter cnt[i] and a captured maximum max[i].
REQ-018 Decrement event dec[i] = flit_wr & flit_vc[i]; increment event inc[i] = credit_in[i].
REQ-019 When reset=0, next cnt[i] SHALL be cnt[i] + inc[i] - dec[i]; a cycle with both inc[i] and dec[i] SHALL leave cnt[i] unchanged.
REQ-020 dec[i] with cnt[i]=0 and inc[i]=0: cnt[i] SHALL hold at 0 and err[0] SHALL set.
REQ-021 inc[i] with cnt[i]=max[i] and dec[i]=0: cnt[i] SHALL hold at max[i] and err[1] SHALL set.
REQ-022 err bits SHALL be sticky until reset.
REQ-023 full[i] = (cnt[i]==0); nearly_full[i] = (cnt[i]<=1); empty[i] = (cnt[i]==max[i]); all decoded combinationally from registered state.
REQ-024 Latency: a counter-changing event at edge N SHALL be reflected on credit and flags after edge N, with no combinational input-to-output path.
REQ-025 status[i] SHALL set on ovc_is_allocated[i] and clear on ovc_is_released[i]; if both are asserted in the same cycle, the set SHALL win.
REQ-026 avalable[i] = ~status[i] & ~full[i] when OVC_ALLOC_MODE=1; avalable[i] = ~status[i] & ~nearly_full[i] when OVC_ALLOC_MODE=0.
REQ-027 A VC with max[i]=0 SHALL report full=1 and avalable=0 until credits arrive; any credit_in[i] on such a VC SHALL increment cnt[i] and raise max[i] to track the new peak (credit_release_en path).
REQ-028 flit_vc with more than one bit set SHALL decrement every flagged VC; the upstream block SHALL NOT drive this case.

Reset
REQ-029 While reset=1, at each clk edge: cnt[i] <= credit_init_val[i], max[i] <= credit_init_val[i], status <= 0, err <= 0.
REQ-030 Reset asserted mid-operation SHALL discard in-flight counts and reload from credit_init_val; inc/dec events in a reset cycle SHALL be ignored.
REQ-031 Post-reset outputs: credit = init values, empty = 1 where init != 0, status = 0, avalable = ~full.

Structure
REQ-032 ovc_info_t, CRDTw and OVC_ALLOC_MODE SHALL remain in pronoc_pkg; this block adds no new typedefs.
REQ-033 The per-VC counter SHALL be a sub-module ovc_credit_cntr, instantiated V times in a generate loop; the top level SHALL also pack the results into ovc_info_t[V-1:0] as an optional output.

Verification
REQ-034 V=4, init=4 on all VCs: 4 flit_wr on VC0 -> credit[0] steps 3,2,1,0; full[0]=1; nearly_full[0]=1 at credit 1.
REQ-035 credit[1]=2, then flit_wr on VC1 and credit_in[1] in the same cycle -> credit[1]=2 and err=0.
REQ-036 credit[2]=0, flit_wr on VC2 -> credit[2]=0 and err[0]=1, persisting until reset.
REQ-037 credit[3]=4 (max), credit_in[3] -> credit[3]=4, err[1]=1, empty[3]=1.
REQ-038 ovc_is_allocated[0] and ovc_is_released[0] in the same cycle -> status[0]=1, avalable[0]=0; next cycle a release only -> status[0]=0.
REQ-039 init=0 on VC1, three credit_in[1] pulses -> credit[1]=3, full[1]=0, then empty[1]=1; mid-run reset with init=2 -> credit[1]=2 one cycle later.
